// File: rtl/nibble_pkg.sv
// rtl/nibble_pkg.sv - shared constants and state encoding for the nibble stimulus generator
package nibble_pkg;

  localparam int NIBBLE_W = 5;

  // Default LFSR start value and Galois tap mask (x^5+x^3+1, right-shifting form)
  localparam logic [NIBBLE_W-1:0] LFSR_SEED_DEF = 5'h15;
  localparam logic [NIBBLE_W-1:0] LFSR_TAPS_DEF = 5'h14;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WALK   = 3'd1,
    S_RANDOM = 3'd2,
    S_FLUSH  = 3'd3,
    S_DONE   = 3'd4
  } stim_state_e;

endpackage

// File: rtl/nibble_lfsr.sv
// rtl/nibble_lfsr.sv - Galois right-shift LFSR; q is the word to issue next
module nibble_lfsr
  import nibble_pkg::*;
#(
  parameter int               WIDTH = NIBBLE_W,
  parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS_DEF,
  parameter logic [WIDTH-1:0] SEED  = LFSR_SEED_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] q
);

  // An all-zero state would lock the register, so a zero seed becomes 1
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

  // Reload on reset or load, otherwise advance one state per step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SEED_EFF;
    end else if (load) begin
      q <= SEED_EFF;
    end else if (step) begin
      q <= q[0] ? ((q >> 1) ^ TAPS) : (q >> 1);
    end
  end

endmodule

// File: rtl/nibble_stim_gen.sv
// rtl/nibble_stim_gen.sv - walk/LFSR/flush stimulus generator with mismatch tally; NIBBLE_STIM_STALL_EN adds RANDOM bubbles
module nibble_stim_gen
  import nibble_pkg::*;
#(
  parameter int               WIDTH        = NIBBLE_W,
  parameter int               NUM_RANDOM   = 32,
  parameter logic [WIDTH-1:0] LFSR_SEED    = LFSR_SEED_DEF,
  parameter logic [WIDTH-1:0] LFSR_TAPS    = LFSR_TAPS_DEF,
  parameter int               FLUSH_CYCLES = 4,
  parameter int               ERR_W        = 8
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             START,
  input  logic             CHECK_OK,
  output logic [WIDTH-1:0] DATA_IN,
  output logic             VALID_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_COUNT
);

  localparam int               IDX_W      = 8;
  localparam logic [IDX_W-1:0] WALK_LAST  = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] RAND_LAST  = IDX_W'(NUM_RANDOM - 1);
  localparam logic [IDX_W-1:0] FLUSH_LAST = IDX_W'(FLUSH_CYCLES - 1);
  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;

  stim_state_e      state_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_d;
  logic [WIDTH-1:0] lfsr_word;
  logic             lfsr_step;
  logic             bubble_next;

`ifdef NIBBLE_STIM_STALL_EN
  logic [1:0]       ph_q;
`endif

  nibble_lfsr #(
    .WIDTH (WIDTH),
    .TAPS  (LFSR_TAPS),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk   (CLK),
    .rst_n (RESET_L),
    .load  (1'b0),
    .step  (lfsr_step),
    .q     (lfsr_word)
  );

  // Saturating mismatch tally; only cycles that show BUSY are counted
  always_comb begin
    err_d = err_q;
    if (busy_q && !CHECK_OK && (err_q != ERR_MAX)) begin
      err_d = err_q + 1'b1;
    end
  end

  // Decide whether the next displayed cycle consumes an LFSR word
  always_comb begin
    bubble_next = 1'b0;
`ifdef NIBBLE_STIM_STALL_EN
    bubble_next = (ph_q == 2'd2);
`endif
    lfsr_step = 1'b0;
    case (state_q)
      S_WALK:   lfsr_step = (idx_q == WALK_LAST);
      S_RANDOM: lfsr_step = (idx_q != RAND_LAST) && !bubble_next;
      default:  lfsr_step = 1'b0;
    endcase
  end

  // Sequencer: state, counters and all outputs register together so each
  // state's outputs appear on the cycle after its entry edge
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
`ifdef NIBBLE_STIM_STALL_EN
      ph_q    <= '0;
`endif
    end else begin
      err_q <= err_d;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (START) begin
            state_q <= S_WALK;
            idx_q   <= '0;
            data_q  <= ONE;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
          end
        end
        S_WALK: begin
          if (idx_q == WALK_LAST) begin
            state_q <= S_RANDOM;
            idx_q   <= '0;
            data_q  <= lfsr_word;
            valid_q <= 1'b1;
`ifdef NIBBLE_STIM_STALL_EN
            ph_q    <= '0;
`endif
          end else begin
            idx_q  <= idx_q + 1'b1;
            data_q <= ONE << (idx_q + 1'b1);
          end
        end
        S_RANDOM: begin
          // idx_q is the index of the last word issued; a bubble never follows the final word
          if (idx_q == RAND_LAST) begin
            state_q <= S_FLUSH;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
          end else if (bubble_next) begin
            data_q  <= '0;
            valid_q <= 1'b0;
          end else begin
            idx_q   <= idx_q + 1'b1;
            data_q  <= lfsr_word;
            valid_q <= 1'b1;
          end
`ifdef NIBBLE_STIM_STALL_EN
          ph_q <= ph_q + 2'd1;
`endif
        end
        S_FLUSH: begin
          if (idx_q == FLUSH_LAST) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign DATA_IN   = data_q;
  assign VALID_IN  = valid_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign PASS      = pass_q;
  assign ERR_COUNT = err_q;

endmodule

// File: tb/tb_nibble_stim_gen.sv
// tb/tb_nibble_stim_gen.sv - self-checking bench for nibble_stim_gen
module tb_nibble_stim_gen;

  localparam int         W    = 5;
  localparam int         NR   = 32;
  localparam int         FL   = 4;
  localparam logic [4:0] SEED = 5'h15;
  localparam logic [4:0] TAPS = 5'h14;
`ifdef NIBBLE_STIM_STALL_EN
  localparam bit         STALL = 1'b1;
`else
  localparam bit         STALL = 1'b0;
`endif

  typedef struct {
    logic       start;
    logic       ok;
    logic       exp_valid;
    logic [4:0] exp_data;
    logic       exp_busy;
  } vec_t;

  logic       CLK      = 1'b0;
  logic       RESET_L  = 1'b0;
  logic       START    = 1'b0;
  logic       CHECK_OK = 1'b1;
  logic [4:0] data_a, data_b;
  logic       valid_a, valid_b, busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [7:0] err_a;
  logic [3:0] err_b;

  int         total = 0;
  int         bad   = 0;
  logic [4:0] m_lfsr;

  always #5 CLK = ~CLK;

  nibble_stim_gen #(
    .WIDTH(W), .NUM_RANDOM(NR), .LFSR_SEED(SEED), .LFSR_TAPS(TAPS),
    .FLUSH_CYCLES(FL), .ERR_W(8)
  ) u_dut (
    .CLK(CLK), .RESET_L(RESET_L), .START(START), .CHECK_OK(CHECK_OK),
    .DATA_IN(data_a), .VALID_IN(valid_a), .BUSY(busy_a), .DONE(done_a),
    .PASS(pass_a), .ERR_COUNT(err_a)
  );

  nibble_stim_gen #(
    .WIDTH(W), .NUM_RANDOM(NR), .LFSR_SEED(SEED), .LFSR_TAPS(TAPS),
    .FLUSH_CYCLES(FL), .ERR_W(4)
  ) u_sat (
    .CLK(CLK), .RESET_L(RESET_L), .START(START), .CHECK_OK(CHECK_OK),
    .DATA_IN(data_b), .VALID_IN(valid_b), .BUSY(busy_b), .DONE(done_b),
    .PASS(pass_b), .ERR_COUNT(err_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] lfsr_next(input logic [4:0] v);
    return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"},  int'(data_a),  0);
    chk({tag, "_valid"}, int'(valid_a), 0);
    chk({tag, "_busy"},  int'(busy_a),  0);
    chk({tag, "_done"},  int'(done_a),  0);
    chk({tag, "_pass"},  int'(pass_a),  0);
    chk({tag, "_err"},   int'(err_a),   0);
    chk({tag, "_err_b"}, int'(err_b),   0);
    chk({tag, "_busy_b"}, int'(busy_b), 0);
  endtask

  function automatic logic pick_ok(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return ($urandom_range(0, 3) != 0);
      2:       return 1'b0;
      default: return !((c >= W + 3) && (c < W + 6));
    endcase
  endfunction

  // One complete run checked against an expected trace built from the rules
  task automatic do_run(input int mode, input bit early_start, input int abort_at);
    logic [4:0] exp_data[$];
    logic       exp_valid[$];
    int         nw, p, zeros;
    logic       ok;
    string      t;
    for (int i = 0; i < W; i++) begin
      exp_data.push_back(5'(1 << i));
      exp_valid.push_back(1'b1);
    end
    nw = 0;
    p  = 0;
    while (nw < NR) begin
      if (STALL && (p % 4 == 3)) begin
        exp_data.push_back(5'h00);
        exp_valid.push_back(1'b0);
      end else begin
        exp_data.push_back(m_lfsr);
        exp_valid.push_back(1'b1);
        m_lfsr = lfsr_next(m_lfsr);
        nw++;
      end
      p++;
    end
    for (int i = 0; i < FL; i++) begin
      exp_data.push_back(5'h00);
      exp_valid.push_back(1'b0);
    end

    START    = 1'b1;
    CHECK_OK = 1'($urandom_range(0, 1));
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    zeros = 0;
    for (int c = 0; c < exp_data.size(); c++) begin
      t = $sformatf("m%0d_c%0d", mode, c);
      chk({t, "_data"},  int'(data_a),  int'(exp_data[c]));
      chk({t, "_valid"}, int'(valid_a), int'(exp_valid[c]));
      chk({t, "_busy"},  int'(busy_a),  1);
      chk({t, "_done"},  int'(done_a),  0);
      chk({t, "_err"},   int'(err_a),   sat(zeros, 255));
      chk({t, "_err_b"}, int'(err_b),   sat(zeros, 15));
      if (c == abort_at) begin
        RESET_L = 1'b0;
        #1;
        chk_all_zero("abort");
        m_lfsr = SEED;
        @(negedge CLK);
        RESET_L = 1'b1;
        @(negedge CLK);
        chk_all_zero("after_abort");
        return;
      end
      ok = pick_ok(mode, c);
      if (!ok) zeros++;
      CHECK_OK = ok;
      if (early_start && (c == exp_data.size() - 1)) START = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
    end
    t = $sformatf("m%0d_end", mode);
    chk({t, "_done"},   int'(done_a),  1);
    chk({t, "_busy"},   int'(busy_a),  0);
    chk({t, "_valid"},  int'(valid_a), 0);
    chk({t, "_data"},   int'(data_a),  0);
    chk({t, "_pass"},   int'(pass_a),  int'(zeros == 0));
    chk({t, "_err"},    int'(err_a),   sat(zeros, 255));
    chk({t, "_err_b"},  int'(err_b),   sat(zeros, 15));
    chk({t, "_pass_b"}, int'(pass_b),  int'(zeros == 0));
    if (!early_start) begin
      for (int i = 0; i < 2; i++) begin
        CHECK_OK = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        chk({t, "_hold_done"}, int'(done_a), 1);
        chk({t, "_hold_err"},  int'(err_a),  sat(zeros, 255));
      end
      CHECK_OK = 1'b1;
    end
  endtask

  initial begin
    vec_t tbl[9];
    int   nvalid, nidle, cyc;

    tbl[0] = '{1'b1, 1'b1, 1'b1, 5'h01, 1'b1};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 5'h02, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 5'h04, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 5'h08, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 5'h10, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 5'h15, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 5'h1E, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 5'h0F, 1'b1};
    if (STALL) tbl[8] = '{1'b0, 1'b1, 1'b0, 5'h00, 1'b1};
    else       tbl[8] = '{1'b0, 1'b1, 1'b1, 5'h13, 1'b1};

    repeat (2) @(negedge CLK);
    chk_all_zero("reset");
    RESET_L  = 1'b1;
    CHECK_OK = 1'b0;
    repeat (2) @(negedge CLK);
    chk_all_zero("idle");

    nvalid = 0;
    nidle  = 0;
    for (int i = 0; i < 9; i++) begin
      START    = tbl[i].start;
      CHECK_OK = tbl[i].ok;
      @(posedge CLK);
      @(negedge CLK);
      chk($sformatf("tbl%0d_valid", i), int'(valid_a), int'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_data", i),  int'(data_a),  int'(tbl[i].exp_data));
      chk($sformatf("tbl%0d_busy", i),  int'(busy_a),  int'(tbl[i].exp_busy));
      chk($sformatf("tbl%0d_err", i),   int'(err_a),   0);
      nvalid += int'(valid_a);
      if (busy_a && !valid_a) nidle++;
    end
    START    = 1'b0;
    CHECK_OK = 1'b1;
    cyc      = 0;
    while ((done_a !== 1'b1) && (cyc < 200)) begin
      @(posedge CLK);
      @(negedge CLK);
      cyc++;
      nvalid += int'(valid_a);
      if (busy_a && !valid_a) nidle++;
    end
    chk("run1_done_in_time", int'(done_a === 1'b1), 1);
    chk("run1_valid_words",  nvalid, W + NR);
    chk("run1_idle_busy",    nidle,  FL + (STALL ? (NR - 1) / 3 : 0));
    chk("run1_pass",         int'(pass_a), 1);
    chk("run1_err",          int'(err_a),  0);
    m_lfsr = SEED;
    repeat (NR) m_lfsr = lfsr_next(m_lfsr);

    do_run(3, 1'b0, -1);
    do_run(2, 1'b0, -1);
    do_run(1, 1'b0, -1);
    do_run(1, 1'b1, -1);
    do_run(1, 1'b0, -1);
    do_run(0, 1'b0, W + 9);
    do_run(0, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
